disp_scroll_ctrl: RTL

DISP_SCROLL_CTRL -- requirements
Module: disp_scroll_ctrl

---
 rtl/disp_pkg.sv | 5 +
 rtl/disp_tick_gen.sv | 18 +
 rtl/disp_scroll_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared display constants and scroll controller state encoding.
package disp_pkg;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
endpackage

// File: rtl/disp_tick_gen.sv
// disp_tick_gen: mod-TICK_DIV counter with enable and sync clear; tick on terminal count.
module disp_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    logic [CW-1:0] cnt;
    assign tick = en && !clr && cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/disp_scroll_ctrl.sv
// disp_scroll_ctrl: scrolls a 4-digit window over a message buffer.
// Define DISP_SCROLL_BLINK_EN to blink the digits while paused.
module disp_scroll_ctrl
    import disp_pkg::*;
#(
    parameter int MSG_DEPTH = 16,
    parameter int TICK_DIV  = 25_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic [$clog2(MSG_DEPTH):0] msg_len,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pause,
    output logic [7:0]                 dig3,
    output logic [7:0]                 dig2,
    output logic [7:0]                 dig1,
    output logic [7:0]                 dig0,
    output logic                       busy,
    output logic                       wrap
);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    state_t state, state_n;
    logic [AW-1:0] pos, pos_n;
    logic [LW-1:0] len, len_n, clamp;
    logic [7:0] mem [MSG_DEPTH];
    logic [7:0] nxt [4];
    logic tick, last, blank;
    // pos < len and len >= 4, so a single conditional subtract replaces the modulo
    function automatic logic [AW-1:0] idx(input logic [AW-1:0] p, input logic [1:0] k, input logic [LW-1:0] l);
        logic [LW:0] s;
        s = (LW+1)'(p) + (LW+1)'(k);
        return s >= (LW+1)'(l) ? AW'(s - (LW+1)'(l)) : AW'(s);
    endfunction
    disp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(clk),
        .rst(rst),
        .en(state == RUN && !pause),
        .clr(state == IDLE || stop),
        .tick(tick)
    );
    assign clamp = msg_len > LW'(MSG_DEPTH) ? LW'(MSG_DEPTH) : msg_len;
    assign last  = LW'(pos) == len - 1'b1;
    always_comb begin
        state_n = state;
        pos_n   = pos;
        len_n   = len;
        if (state == IDLE) begin
            if (start && !stop && clamp >= LW'(4)) begin
                state_n = RUN;
                pos_n   = '0;
                len_n   = clamp;
            end
        end else if (stop) begin
            state_n = IDLE;
            pos_n   = '0;
        end else if (state == RUN) begin
            if (pause) state_n = HOLD;
            else if (tick) pos_n = last ? '0 : pos + 1'b1;
        end else if (!pause) begin
            state_n = RUN;
        end
        for (int k = 0; k < 4; k++) nxt[k] = mem[idx(pos_n, 2'(k), len_n)];
    end
`ifdef DISP_SCROLL_BLINK_EN
    localparam int BW = $clog2(2 * TICK_DIV);
    logic [BW-1:0] blk, blk_n;
    assign blk_n = (state == HOLD && state_n == HOLD) ? (blk == BW'(2 * TICK_DIV - 1) ? '0 : blk + 1'b1) : '0;
    assign blank = state_n == IDLE || (state_n == HOLD && blk_n >= BW'(TICK_DIV));
    always_ff @(posedge clk) blk <= rst ? '0 : blk_n;
`else
    assign blank = state_n == IDLE;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pos   <= '0;
            len   <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
            dig3  <= SEG_BLANK;
            dig2  <= SEG_BLANK;
            dig1  <= SEG_BLANK;
            dig0  <= SEG_BLANK;
            for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= SEG_BLANK;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            len   <= len_n;
            busy  <= state_n != IDLE;
            wrap  <= tick && last;
            dig3  <= blank ? SEG_BLANK : nxt[0];
            dig2  <= blank ? SEG_BLANK : nxt[1];
            dig1  <= blank ? SEG_BLANK : nxt[2];
            dig0  <= blank ? SEG_BLANK : nxt[3];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end
endmodule
